// File: rtl/sm4_pkg.sv
// SM4 shared definitions: S-box, FK/CK constants, the two linear transforms, FSM encoding.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package sm4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2
  } state_t;

  localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

  // Entry 0 sits in the most significant byte, so S(x) lives at index 255-x (= ~x).
  localparam logic [255:0][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Data-path linear transform L.
  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  // Key-schedule linear transform L'.
  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  // CK_i byte j = (4i + j) * 7 mod 256; the low two bits of 4i are zero so OR acts as add.
  function automatic logic [31:0] get_cki(input logic [4:0] i);
    logic [31:0] ck;
    logic [7:0]  n;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      n = {1'b0, i, 2'b00} | 8'(j);
      ck[31-8*j -: 8] = n * 8'd7;
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_dec_cir_if.sv
// Request/response bundle of the iterative SM4 decryptor.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side; result side has none (out_valid pulse).
// Ports: ciphertext_in, key_in, in_valid (to DUT); in_ready, result_out, out_valid (from DUT).
interface sm4_dec_cir_if;
  logic [127:0] ciphertext_in;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] result_out;
  logic         out_valid;

  modport master (
    output ciphertext_in, key_in, in_valid,
    input  in_ready, result_out, out_valid
  );

  modport slave (
    input  ciphertext_in, key_in, in_valid,
    output in_ready, result_out, out_valid
  );
endinterface

// File: rtl/sm4_rk_store.sv
// 32 x 32-bit round-key register file, one write port and one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none.
// Ports: clk; we/waddr/wdata (write); raddr -> rdata (read). Contents are not reset.
module sm4_rk_store (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sm4_rounds.sv
// One SM4 key-expansion round and one SM4 data round, both purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: key_in/first_round/round_idx -> key_out/rk_out; data_in/rk_in -> data_out.
module one_round_for_key_exp
  import sm4_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic         first_round,
  input  logic [4:0]   round_idx,
  output logic [127:0] key_out,
  output logic [31:0]  rk_out
);
  logic [127:0] k;

  // The master key is whitened with FK only on entry to the schedule.
  assign k       = first_round ? (key_in ^ FK) : key_in;
  assign rk_out  = k[127:96] ^ l_key(tau(k[95:64] ^ k[63:32] ^ k[31:0] ^ get_cki(round_idx)));
  assign key_out = {k[95:0], rk_out};
endmodule

module one_round_for_encdec
  import sm4_pkg::*;
(
  input  logic [127:0] data_in,
  input  logic [31:0]  rk_in,
  output logic [127:0] data_out
);
  assign data_out = {data_in[95:0],
                     data_in[127:96] ^ l_enc(tau(data_in[95:64] ^ data_in[63:32] ^ data_in[31:0] ^ rk_in))};
endmodule

// File: rtl/sm4_dec_cir.sv
// Iterative SM4 decryptor: expands the key into a round-key store, then 32 rounds with rk[31..0].
// Latency: out_valid the cycle after accept edge +64 (key expanded) or +32 (cached key reused).
// Backpressure: in_ready only in IDLE, requests while busy are ignored; out_valid is a 1-cycle pulse.
// Ports: clk, reset (async, active-high), bus (sm4_dec_cir_if.slave).
module sm4_dec_cir
  import sm4_pkg::*;
#(
  parameter int KEY_CACHE = 1
) (
  input  logic          clk,
  input  logic          reset,
  sm4_dec_cir_if.slave  bus
);
  state_t       state, state_nxt;
  logic [4:0]   cnt;
  logic [127:0] data_q;
  logic [127:0] kreg;
  logic [127:0] cached_key;
  logic         cache_valid;
  logic [127:0] result_q;
  logic         out_valid_q;

  logic         key_hit;
  logic         first_round;
  logic [127:0] kexp_out;
  logic [31:0]  rk_new;
  logic [31:0]  rk_rd;
  logic [127:0] dec_out;

  // With KEY_CACHE=0 this folds to constant 0 and the comparator disappears.
  assign key_hit     = (KEY_CACHE != 0) && cache_valid && (bus.key_in == cached_key);
  assign first_round = (state == KEYEXP) && (cnt == 5'd0);

  one_round_for_key_exp u_kexp (
    .key_in      (kreg),
    .first_round (first_round),
    .round_idx   (cnt),
    .key_out     (kexp_out),
    .rk_out      (rk_new)
  );

  sm4_rk_store u_rk_store (
    .clk   (clk),
    .we    (state == KEYEXP),
    .waddr (cnt),
    .wdata (rk_new),
    .raddr (5'd31 - cnt),
    .rdata (rk_rd)
  );

  one_round_for_encdec u_round (
    .data_in  (data_q),
    .rk_in    (rk_rd),
    .data_out (dec_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = key_hit ? DEC : KEYEXP;
      KEYEXP:  if (cnt == 5'd31) state_nxt = DEC;
      DEC:     if (cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= 5'd0;
      data_q      <= '0;
      kreg        <= '0;
      cached_key  <= '0;
      cache_valid <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.ciphertext_in;
            kreg       <= bus.key_in;
            cached_key <= bus.key_in;
            cnt        <= 5'd0;
            // Store is about to be overwritten, so it no longer matches any key.
            if (!key_hit) cache_valid <= 1'b0;
          end
        end
        KEYEXP: begin
          kreg <= kexp_out;
          if (cnt == 5'd31) begin
            cache_valid <= 1'b1;
            cnt         <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DEC: begin
          data_q <= dec_out;
          if (cnt == 5'd31) begin
            result_q    <= {dec_out[31:0], dec_out[63:32], dec_out[95:64], dec_out[127:96]};
            out_valid_q <= 1'b1;
            cnt         <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.result_out = result_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_sm4_dec_cir.sv
// Bench for sm4_dec_cir: directed vectors plus encrypt-then-decrypt round trips.
// Latency: checks 64 / 32 cycle completion against a key-cache model.
// Backpressure: drives in_valid against in_ready; result pulses checked by a scoreboard monitor.
module tb_sm4_dec_cir;
  localparam logic [127:0] K1  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT1 = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [255:0][7:0] TB_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic [127:0] m_key = '0;
  bit   m_ok = 1'b0;
  bit   nc_done = 1'b0;

  sm4_dec_cir_if bus ();
  sm4_dec_cir_if bus_nc ();

  sm4_dec_cir #(.KEY_CACHE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sm4_dec_cir #(.KEY_CACHE(0)) dut_nc (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] tb_sub(input logic [31:0] w);
    return {TB_SBOX[~w[31:24]], TB_SBOX[~w[23:16]], TB_SBOX[~w[15:8]], TB_SBOX[~w[7:0]]};
  endfunction

  // Reference SM4 encryption (forward key order), used to build ciphertexts for round trips.
  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] t;
    logic [31:0] ck;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      t = tb_sub(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ {t[18:0], t[31:19]} ^ {t[8:0], t[31:9]};
    end
    x[0] = pt[127:96]; x[1] = pt[95:64]; x[2] = pt[63:32]; x[3] = pt[31:0];
    for (int i = 0; i < 32; i++) begin
      t = tb_sub(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ t ^ {t[29:0], t[31:30]} ^ {t[21:0], t[31:22]}
                        ^ {t[13:0], t[31:14]} ^ {t[7:0], t[31:8]};
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                      input bit expect_it, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(bus.in_ready == 1'b1, "in_ready_wait", 128'(bus.in_ready), 128'd1);
    bus.ciphertext_in = ct;
    bus.key_in        = key;
    bus.in_valid      = 1'b1;
    if (expect_it) begin
      e.pt  = pt;
      e.lat = (m_ok && key == m_key) ? 32 : 64;
      e.acc = cyc + 1;
      sb.push_back(e);
      m_key = key;
      m_ok  = 1'b1;
    end
    @(negedge clk);
    if (hold) begin
      n = 0;
      while (!bus.in_ready && n < 200) begin
        bus.ciphertext_in = rnd128();
        bus.key_in        = rnd128();
        @(negedge clk);
        n++;
      end
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  // Scoreboard monitor.
  initial begin
    bit   ov_prev;
    exp_t e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ov_prev) chk(bus.out_valid == 1'b0, "out_valid_width", 128'(bus.out_valid), 128'd0);
      if (bus.out_valid) begin
        chk(sb.size() != 0, "spurious_out_valid", 128'(sb.size()), 128'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk(bus.result_out == e.pt, "plaintext", bus.result_out, e.pt);
          chk((cyc - e.acc) == e.lat, "latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  // KEY_CACHE=0 instance: two identical back-to-back requests both take the full 64 cycles.
  initial begin
    int n;
    int acc;
    bus_nc.in_valid      = 1'b0;
    bus_nc.ciphertext_in = '0;
    bus_nc.key_in        = '0;
    repeat (5) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (!bus_nc.in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      bus_nc.ciphertext_in = CT1;
      bus_nc.key_in        = K1;
      bus_nc.in_valid      = 1'b1;
      acc = cyc + 1;
      @(negedge clk);
      bus_nc.in_valid = 1'b0;
      n = 0;
      while (!bus_nc.out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk(bus_nc.out_valid == 1'b1, "nc_out_valid", 128'(bus_nc.out_valid), 128'd1);
      chk((cyc - acc) == 64, "nc_latency", 128'(cyc - acc), 128'd64);
      chk(bus_nc.result_out == PT1, "nc_plaintext", bus_nc.result_out, PT1);
    end
    nc_done = 1'b1;
  end

  initial begin
    logic [127:0] ka, kb, k, pt;
    int n;
    reset = 1'b1;
    bus.in_valid      = 1'b0;
    bus.ciphertext_in = '0;
    bus.key_in        = '0;
    repeat (3) @(negedge clk);
    chk(bus.result_out == '0, "reset_result_out", bus.result_out, 128'd0);
    chk(bus.out_valid == 1'b0, "reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk(bus.in_ready == 1'b1, "reset_in_ready", 128'(bus.in_ready), 128'd1);
    reset = 1'b0;

    // Standard vector cold, then the same request back-to-back on the out_valid cycle.
    send(CT1, K1, PT1, 1'b1, 1'b0);
    send(CT1, K1, PT1, 1'b1, 1'b0);
    drain();

    // Round trips under two keys chosen at random per request.
    ka = rnd128();
    kb = rnd128();
    for (int i = 0; i < 200; i++) begin
      k  = ($urandom_range(0, 1) != 0) ? ka : kb;
      pt = rnd128();
      send(ref_enc(k, pt), k, pt, 1'b1, 1'b0);
    end
    drain();

    // in_valid held with junk while busy; the block present at the IDLE edge is taken next.
    pt = rnd128();
    send(CT1, K1, PT1, 1'b1, 1'b1);
    send(ref_enc(K1, pt), K1, pt, 1'b1, 1'b0);
    drain();

    // Abort during key expansion (different key forces KEYEXP), then rerun.
    send(CT1, ka ^ K1 ^ 128'h1, PT1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    m_ok = 1'b0;
    #1;
    chk(bus.in_ready == 1'b1, "abort_kexp_in_ready", 128'(bus.in_ready), 128'd1);
    chk(bus.out_valid == 1'b0, "abort_kexp_out_valid", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    send(CT1, K1, PT1, 1'b1, 1'b0);
    drain();

    // Abort during a warm decrypt: outputs clear without a clock edge, cache is dropped.
    send(CT1, K1, PT1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    m_ok = 1'b0;
    #1;
    chk(bus.result_out == '0, "async_reset_result_out", bus.result_out, 128'd0);
    chk(bus.out_valid == 1'b0, "async_reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk(bus.in_ready == 1'b1, "async_reset_in_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    send(CT1, K1, PT1, 1'b1, 1'b0);
    drain();

    n = 0;
    while (!nc_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(nc_done == 1'b1, "nc_done", 128'(nc_done), 128'd1);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
